// File: rtl/textbuf_pkg.sv
// Shared types and default geometry for the text-mode character buffer.
package textbuf_pkg;

  localparam int DEF_ADDRW = 11;
  localparam int DEF_DATAW = 16;
  localparam int DEF_DEPTH = 2040;

  typedef struct packed {
    logic [3:0] bg;
    logic [3:0] fg;
    logic [7:0] glyph;
  } cell_t;

  localparam cell_t DEF_CLEAR_CELL = '{bg: 4'h0, fg: 4'h0, glyph: 8'h20};
  localparam logic [15:0] DEF_CLEAR_WORD = DEF_CLEAR_CELL;

  typedef enum logic [0:0] {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; a masked requester is not eligible this cycle.
module rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic req_a,
  input  logic req_b,
  input  logic mask_a,
  input  logic mask_b,
  output logic grant_a,
  output logic grant_b
);

  logic last_b_q;
  logic last_b_d;
  logic elig_a;
  logic elig_b;

  // Grant selection and last-grant bookkeeping
  always_comb begin
    elig_a   = req_a & ~mask_a;
    elig_b   = req_b & ~mask_b;
    grant_a  = 1'b0;
    grant_b  = 1'b0;
    last_b_d = last_b_q;
    if (en) begin
      if (elig_a && elig_b) begin
        grant_a = last_b_q;
        grant_b = ~last_b_q;
      end else begin
        grant_a = elig_a;
        grant_b = elig_b;
      end
      if (grant_a || grant_b) begin
        last_b_d = grant_b;
      end else begin
        last_b_d = last_b_q;
      end
    end else begin
      last_b_d = last_b_q;
    end
  end

  // Last-grant register; B after reset so A takes the first tie
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_b_q <= 1'b1;
    end else begin
      last_b_q <= last_b_d;
    end
  end

endmodule

// File: rtl/textbuf_arb.sv
// Round-robin sharing of the text buffer port between CPU (A) and console (B),
// plus an exclusive full-buffer clear built only when TEXTBUF_CLEAR_EN is defined.
module textbuf_arb
  import textbuf_pkg::*;
#(
  parameter int ADDRW = DEF_ADDRW,
  parameter int DATAW = DEF_DATAW,
  parameter int DEPTH = DEF_DEPTH,
  parameter logic [DATAW-1:0] CLEAR_WORD = DATAW'(DEF_CLEAR_WORD)
) (
  input  logic             clk_sys,
  input  logic             rst_sys_n,
  input  logic             a_req,
  input  logic             a_we,
  input  logic [ADDRW-1:0] a_addr,
  input  logic [DATAW-1:0] a_wdata,
  output logic             a_ack,
  output logic             a_rvalid,
  output logic [DATAW-1:0] a_rdata,
  input  logic             b_req,
  input  logic             b_we,
  input  logic [ADDRW-1:0] b_addr,
  input  logic [DATAW-1:0] b_wdata,
  output logic             b_ack,
  output logic             b_rvalid,
  output logic [DATAW-1:0] b_rdata,
  input  logic             clr_start,
  output logic             clr_busy,
  output logic             mem_en,
  output logic             mem_we,
  output logic [ADDRW-1:0] mem_addr,
  output logic [DATAW-1:0] mem_wdata,
  input  logic [DATAW-1:0] mem_rdata
);

  localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(DEPTH - 1);
  localparam logic [ADDRW-1:0] ADDR_ONE  = {{(ADDRW-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic             mem_en_q, mem_en_d;
  logic             mem_we_q, mem_we_d;
  logic [ADDRW-1:0] mem_addr_q, mem_addr_d;
  logic [DATAW-1:0] mem_wdata_q, mem_wdata_d;
  logic             a_ack_q, a_ack_d;
  logic             b_ack_q, b_ack_d;
  logic             a_rvalid_q, a_rvalid_d;
  logic             b_rvalid_q, b_rvalid_d;
  logic             clr_busy_q, clr_busy_d;
  logic             clr_go;
  logic             arb_en;
  logic             grant_a;
  logic             grant_b;

`ifdef TEXTBUF_CLEAR_EN
  assign clr_go = clr_start;
`else
  logic unused_clr_start;
  assign unused_clr_start = clr_start;
  assign clr_go = 1'b0;
`endif

  assign arb_en = (state_q == ARB) && !clr_go;

  rr_arb2 u_rr_arb2 (
    .clk     (clk_sys),
    .rst_n   (rst_sys_n),
    .en      (arb_en),
    .req_a   (a_req),
    .req_b   (b_req),
    .mask_a  (a_ack_q),
    .mask_b  (b_ack_q),
    .grant_a (grant_a),
    .grant_b (grant_b)
  );

  // Next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    a_ack_d     = 1'b0;
    b_ack_d     = 1'b0;
    clr_busy_d  = 1'b0;
    // a transaction acked last cycle returns its read data now, whatever the state
    a_rvalid_d  = a_ack_q & ~mem_we_q;
    b_rvalid_d  = b_ack_q & ~mem_we_q;
    case (state_q)
      ARB: begin
        if (clr_go) begin
          state_d     = CLEAR;
          mem_en_d    = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = {ADDRW{1'b0}};
          mem_wdata_d = CLEAR_WORD;
          clr_busy_d  = 1'b1;
        end else if (grant_a) begin
          mem_en_d    = 1'b1;
          mem_we_d    = a_we;
          mem_addr_d  = a_addr;
          mem_wdata_d = a_wdata;
          a_ack_d     = 1'b1;
        end else if (grant_b) begin
          mem_en_d    = 1'b1;
          mem_we_d    = b_we;
          mem_addr_d  = b_addr;
          mem_wdata_d = b_wdata;
          b_ack_d     = 1'b1;
        end else begin
          state_d = ARB;
        end
      end
      CLEAR: begin
        // mem_addr_q doubles as the fill counter; it stops at the last cell
        if (mem_addr_q == LAST_ADDR) begin
          state_d = ARB;
        end else begin
          mem_en_d    = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = mem_addr_q + ADDR_ONE;
          mem_wdata_d = CLEAR_WORD;
          clr_busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = ARB;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk_sys) begin
    if (!rst_sys_n) begin
      state_q     <= ARB;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {ADDRW{1'b0}};
      mem_wdata_q <= {DATAW{1'b0}};
      a_ack_q     <= 1'b0;
      b_ack_q     <= 1'b0;
      a_rvalid_q  <= 1'b0;
      b_rvalid_q  <= 1'b0;
      clr_busy_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      a_ack_q     <= a_ack_d;
      b_ack_q     <= b_ack_d;
      a_rvalid_q  <= a_rvalid_d;
      b_rvalid_q  <= b_rvalid_d;
      clr_busy_q  <= clr_busy_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign a_ack     = a_ack_q;
  assign b_ack     = b_ack_q;
  assign a_rvalid  = a_rvalid_q;
  assign b_rvalid  = b_rvalid_q;
  assign clr_busy  = clr_busy_q;
  // memory data arrives one cycle after issue, so it is forwarded, gated to 0 when idle
  assign a_rdata   = a_rvalid_q ? mem_rdata : {DATAW{1'b0}};
  assign b_rdata   = b_rvalid_q ? mem_rdata : {DATAW{1'b0}};

endmodule

// File: tb/tb_textbuf_arb.sv
// Directed bench for textbuf_arb with a behavioural single-port buffer model.
module tb_textbuf_arb;

  localparam int ADDRW = 11;
  localparam int DATAW = 16;
  localparam int DEPTH = 2040;

  logic             clk_sys = 1'b0;
  logic             rst_sys_n;
  logic             a_req, a_we, b_req, b_we, clr_start;
  logic [ADDRW-1:0] a_addr, b_addr;
  logic [DATAW-1:0] a_wdata, b_wdata;
  logic             a_ack, a_rvalid, b_ack, b_rvalid, clr_busy;
  logic [DATAW-1:0] a_rdata, b_rdata;
  logic             mem_en, mem_we;
  logic [ADDRW-1:0] mem_addr;
  logic [DATAW-1:0] mem_wdata;
  logic [DATAW-1:0] mem_rdata = 16'h0000;

  logic [DATAW-1:0] mem [0:2047];
  logic             fill_en = 1'b0;
  logic [DATAW-1:0] fill_val = 16'h0000;
  logic             poke_en = 1'b0;
  logic [ADDRW-1:0] poke_addr = 11'd0;
  logic [DATAW-1:0] poke_val = 16'h0000;

  int errors = 0;
  int checks = 0;

  always #5 clk_sys = ~clk_sys;

  textbuf_arb dut (
    .clk_sys   (clk_sys),
    .rst_sys_n (rst_sys_n),
    .a_req     (a_req),
    .a_we      (a_we),
    .a_addr    (a_addr),
    .a_wdata   (a_wdata),
    .a_ack     (a_ack),
    .a_rvalid  (a_rvalid),
    .a_rdata   (a_rdata),
    .b_req     (b_req),
    .b_we      (b_we),
    .b_addr    (b_addr),
    .b_wdata   (b_wdata),
    .b_ack     (b_ack),
    .b_rvalid  (b_rvalid),
    .b_rdata   (b_rdata),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Single-port buffer, 1-cycle read latency; fill/poke are bench-side preloads
  always @(posedge clk_sys) begin
    if (fill_en) begin
      for (int i = 0; i < 2048; i++) mem[i] <= fill_val;
    end else if (poke_en) begin
      mem[poke_addr] <= poke_val;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else mem_rdata <= mem[mem_addr];
    end
  end

  task automatic test_reset();
    logic [65:0] all_out;
    rst_sys_n = 1'b0;
    repeat (2) @(negedge clk_sys);
    all_out = {a_ack, a_rvalid, a_rdata, b_ack, b_rvalid, b_rdata, clr_busy,
               mem_en, mem_we, mem_addr, mem_wdata};
    checks++;
    if (all_out !== 66'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", all_out);
    end
    rst_sys_n = 1'b1;
    @(negedge clk_sys);
  endtask

  task automatic test_solo_read();
    poke_addr = 11'd5; poke_val = 16'h1F41; poke_en = 1'b1;
    @(negedge clk_sys);
    poke_en = 1'b0;
    a_req = 1'b1; a_we = 1'b0; a_addr = 11'd5;
    @(negedge clk_sys);
    checks++;
    if ({a_ack, b_ack, mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 1'b1, 1'b0, 11'd5}) begin
      errors++;
      $display("FAIL solo_issue: ack/back/en/we/addr got %b %b %b %b %0d expected 1 0 1 0 5",
               a_ack, b_ack, mem_en, mem_we, mem_addr);
    end
    a_req = 1'b0;
    @(negedge clk_sys);
    checks++;
    if ({a_rvalid, a_rdata, a_ack, b_rvalid} !== {1'b1, 16'h1F41, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL solo_rdata: rvalid/rdata/ack/brvalid got %b %h %b %b expected 1 1f41 0 0",
               a_rvalid, a_rdata, a_ack, b_rvalid);
    end
    @(negedge clk_sys);
    checks++;
    if ({a_rvalid, mem_en} !== 2'b00) begin
      errors++;
      $display("FAIL solo_idle: rvalid/en got %b %b expected 0 0", a_rvalid, mem_en);
    end
  endtask

  task automatic test_tie();
    logic exp_a;
    rst_sys_n = 1'b0;
    @(negedge clk_sys);
    rst_sys_n = 1'b1;
    a_req = 1'b1; a_we = 1'b1; a_addr = 11'd10; a_wdata = 16'h1111;
    b_req = 1'b1; b_we = 1'b1; b_addr = 11'd11; b_wdata = 16'h2222;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_sys);
      exp_a = ((i % 2) == 0);
      checks++;
      if ({a_ack, b_ack, mem_en, mem_we, mem_addr, mem_wdata} !==
          {exp_a, ~exp_a, 1'b1, 1'b1, exp_a ? 11'd10 : 11'd11, exp_a ? 16'h1111 : 16'h2222}) begin
        errors++;
        $display("FAIL tie_grant[%0d]: aack/back/en/we/addr/wdata got %b %b %b %b %0d %h expected A=%b",
                 i, a_ack, b_ack, mem_en, mem_we, mem_addr, mem_wdata, exp_a);
      end
    end
    a_req = 1'b0; b_req = 1'b0;
    @(negedge clk_sys);
    checks++;
    if ({mem_en, a_ack, b_ack, a_rvalid, b_rvalid} !== 5'b00000) begin
      errors++;
      $display("FAIL tie_drain: en/aack/back/arv/brv got %b %b %b %b %b expected all 0",
               mem_en, a_ack, b_ack, a_rvalid, b_rvalid);
    end
    checks++;
    if ({mem[10], mem[11]} !== {16'h1111, 16'h2222}) begin
      errors++;
      $display("FAIL tie_mem: cells 10/11 got %h %h expected 1111 2222", mem[10], mem[11]);
    end
  endtask

  task automatic test_back_to_back();
    a_req = 1'b1; a_we = 1'b1; a_addr = 11'd20; a_wdata = 16'hAAAA;
    @(negedge clk_sys);
    checks++;
    if ({a_ack, mem_en, mem_addr} !== {1'b1, 1'b1, 11'd20}) begin
      errors++;
      $display("FAIL b2b_first: ack/en/addr got %b %b %0d expected 1 1 20", a_ack, mem_en, mem_addr);
    end
    a_addr = 11'd21; a_wdata = 16'hBBBB;
    @(negedge clk_sys);
    checks++;
    if ({a_ack, mem_en} !== 2'b00) begin
      errors++;
      $display("FAIL b2b_masked: ack/en got %b %b expected 0 0", a_ack, mem_en);
    end
    @(negedge clk_sys);
    checks++;
    if ({a_ack, mem_addr, mem_wdata} !== {1'b1, 11'd21, 16'hBBBB}) begin
      errors++;
      $display("FAIL b2b_second: ack/addr/wdata got %b %0d %h expected 1 21 bbbb", a_ack, mem_addr, mem_wdata);
    end
    a_req = 1'b0;
    @(negedge clk_sys);
    checks++;
    if ({a_ack, mem_en, a_rvalid} !== 3'b000) begin
      errors++;
      $display("FAIL b2b_end: ack/en/rvalid got %b %b %b expected 0 0 0", a_ack, mem_en, a_rvalid);
    end
  endtask

  task automatic test_contested_read();
    a_req = 1'b1; a_we = 1'b0; a_addr = 11'd5;
    b_req = 1'b1; b_we = 1'b0; b_addr = 11'd10;
    @(negedge clk_sys);
    checks++;
    if ({b_ack, a_ack, mem_addr} !== {1'b1, 1'b0, 11'd10}) begin
      errors++;
      $display("FAIL contest_b_first: back/aack/addr got %b %b %0d expected 1 0 10", b_ack, a_ack, mem_addr);
    end
    b_req = 1'b0;
    @(negedge clk_sys);
    checks++;
    if ({a_ack, mem_addr, b_rvalid, b_rdata} !== {1'b1, 11'd5, 1'b1, 16'h1111}) begin
      errors++;
      $display("FAIL contest_a_second: aack/addr/brv/brdata got %b %0d %b %h expected 1 5 1 1111",
               a_ack, mem_addr, b_rvalid, b_rdata);
    end
    a_req = 1'b0;
    @(negedge clk_sys);
    checks++;
    if ({a_rvalid, a_rdata, b_rvalid, mem_en} !== {1'b1, 16'h1F41, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL contest_a_rdata: arv/ardata/brv/en got %b %h %b %b expected 1 1f41 0 0",
               a_rvalid, a_rdata, b_rvalid, mem_en);
    end
  endtask

`ifdef TEXTBUF_CLEAR_EN
  task automatic test_clear_pending();
    int busy_cnt;
    int bad;
    int guard;
    fill_val = 16'hFFFF; fill_en = 1'b1;
    @(negedge clk_sys);
    fill_en = 1'b0;
    clr_start = 1'b1;
    b_req = 1'b1; b_we = 1'b1; b_addr = 11'd7; b_wdata = 16'hBEEF;
    @(negedge clk_sys);
    clr_start = 1'b0;
    busy_cnt = 0; bad = 0; guard = 0;
    while (clr_busy === 1'b1 && guard < 3000) begin
      if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== busy_cnt[10:0] ||
          mem_wdata !== 16'h0020 || b_ack !== 1'b0) bad++;
      busy_cnt++;
      guard++;
      clr_start = (busy_cnt == 500);
      @(negedge clk_sys);
    end
    clr_start = 1'b0;
    checks++;
    if (busy_cnt !== 2040) begin
      errors++;
      $display("FAIL clear_busy_len: got %0d cycles expected 2040", busy_cnt);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL clear_sequence: got %0d bad cycles expected 0", bad);
    end
    checks++;
    if ({b_ack, mem_en} !== 2'b00) begin
      errors++;
      $display("FAIL clear_gap: back/en got %b %b expected 0 0", b_ack, mem_en);
    end
    @(negedge clk_sys);
    checks++;
    if ({b_ack, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 11'd7, 16'hBEEF}) begin
      errors++;
      $display("FAIL clear_pending_b: ack/we/addr/wdata got %b %b %0d %h expected 1 1 7 beef",
               b_ack, mem_we, mem_addr, mem_wdata);
    end
    b_req = 1'b0;
    @(negedge clk_sys);
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem[i] !== ((i == 7) ? 16'hBEEF : 16'h0020)) bad++;
    end
    checks++;
    if (bad !== 0 || mem[DEPTH] !== 16'hFFFF) begin
      errors++;
      $display("FAIL clear_contents: got %0d bad cells, cell 2040=%h expected 0 bad, ffff",
               bad, mem[DEPTH]);
    end
  endtask

  task automatic test_clear_reset();
    int busy_cnt;
    int bad;
    logic [65:0] all_out;
    fill_val = 16'hFFFF; fill_en = 1'b1;
    @(negedge clk_sys);
    fill_en = 1'b0;
    clr_start = 1'b1;
    @(negedge clk_sys);
    clr_start = 1'b0;
    busy_cnt = 0;
    while (busy_cnt < 99) begin
      @(negedge clk_sys);
      busy_cnt++;
    end
    checks++;
    if ({clr_busy, mem_addr} !== {1'b1, 11'd99}) begin
      errors++;
      $display("FAIL clear_mid: busy/addr got %b %0d expected 1 99", clr_busy, mem_addr);
    end
    rst_sys_n = 1'b0;
    @(negedge clk_sys);
    all_out = {a_ack, a_rvalid, a_rdata, b_ack, b_rvalid, b_rdata, clr_busy,
               mem_en, mem_we, mem_addr, mem_wdata};
    checks++;
    if (all_out !== 66'd0) begin
      errors++;
      $display("FAIL clear_reset_outputs: got %h expected 0", all_out);
    end
    rst_sys_n = 1'b1;
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem[i] !== ((i < 100) ? 16'h0020 : 16'hFFFF)) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL clear_reset_cells: got %0d bad cells expected 0", bad);
    end
    a_req = 1'b1; a_we = 1'b1; a_addr = 11'd300; a_wdata = 16'h1234;
    @(negedge clk_sys);
    checks++;
    if ({a_ack, clr_busy, mem_addr, mem_wdata} !== {1'b1, 1'b0, 11'd300, 16'h1234}) begin
      errors++;
      $display("FAIL clear_reset_arb: ack/busy/addr/wdata got %b %b %0d %h expected 1 0 300 1234",
               a_ack, clr_busy, mem_addr, mem_wdata);
    end
    a_req = 1'b0;
    @(negedge clk_sys);
  endtask
`else
  task automatic test_no_clear();
    clr_start = 1'b1;
    a_req = 1'b1; a_we = 1'b0; a_addr = 11'd5;
    @(negedge clk_sys);
    clr_start = 1'b0;
    checks++;
    if ({clr_busy, a_ack, mem_en, mem_we, mem_addr} !== {1'b0, 1'b1, 1'b1, 1'b0, 11'd5}) begin
      errors++;
      $display("FAIL noclear_issue: busy/ack/en/we/addr got %b %b %b %b %0d expected 0 1 1 0 5",
               clr_busy, a_ack, mem_en, mem_we, mem_addr);
    end
    a_req = 1'b0;
    @(negedge clk_sys);
    checks++;
    if ({clr_busy, a_rvalid, a_rdata} !== {1'b0, 1'b1, 16'h1F41}) begin
      errors++;
      $display("FAIL noclear_rdata: busy/rvalid/rdata got %b %b %h expected 0 1 1f41",
               clr_busy, a_rvalid, a_rdata);
    end
  endtask
`endif

  initial begin
    rst_sys_n = 1'b0;
    a_req = 1'b0; a_we = 1'b0; a_addr = 11'd0; a_wdata = 16'h0000;
    b_req = 1'b0; b_we = 1'b0; b_addr = 11'd0; b_wdata = 16'h0000;
    clr_start = 1'b0;
    test_reset();
    test_solo_read();
    test_tie();
    test_back_to_back();
    test_contested_read();
`ifdef TEXTBUF_CLEAR_EN
    test_clear_pending();
    test_clear_reset();
`else
    test_no_clear();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
